// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter: shares one serial DAC port (sync_bar/din) between two
// frame requesters. Round-robin grant, MSB-first serialization, enforced
// sync_bar high gap between frames, per-requester ack/done pulses.
// FRAME_BITS must be >= 2 and GAP_CYCLES >= 1.
module dac_spi_arbiter #(
  parameter int FRAME_BITS = 24,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  req0,
  input  logic [FRAME_BITS-1:0] data0,
  output logic                  ack0,
  output logic                  done0,
  input  logic                  req1,
  input  logic [FRAME_BITS-1:0] data1,
  output logic                  ack1,
  output logic                  done1,
  output logic                  sync_bar,
  output logic                  din,
  output logic                  busy,
  output logic                  last_grant,
  output logic [15:0]           frame_count
);

  // Counter widths; a single-value counter still needs one bit.
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;      // frame word, consumed from the top
  logic [BW-1:0]         bit_cnt;    // bits still to emit after the current one
  logic [GW-1:0]         gap_cnt;    // remaining gap cycles after this one
  logic                  cur;        // requester owning the frame in flight
  logic [15:0]           frame_cnt;

  logic                  grant_valid;
  logic                  grant_sel;
  logic [FRAME_BITS-1:0] grant_word;

  assign frame_count = frame_cnt;

  // Round-robin pick: a lone requester wins; on contention the one not
  // granted last time wins.
  always_comb begin
    grant_valid = enable && (req0 || req1);
    grant_sel   = 1'b0;
    if (req0 && req1) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = req1;
    end
    grant_word  = grant_sel ? data1 : data0;
  end

  // Arbiter/serializer FSM; every output is a register so the DAC pins
  // never see combinational glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      cur        <= 1'b0;
      frame_cnt  <= '0;
      sync_bar   <= 1'b1;
      din        <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;   // so requester 0 wins the first contention
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            shreg      <= grant_word;
            din        <= grant_word[FRAME_BITS-1];
            sync_bar   <= 1'b0;
            busy       <= 1'b1;
            cur        <= grant_sel;
            last_grant <= grant_sel;
            bit_cnt    <= BW'(FRAME_BITS - 1);
            if (grant_sel) begin
              ack1 <= 1'b1;
            end else begin
              ack0 <= 1'b1;
            end
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            // Last bit has been on the wire for its full cycle: close frame.
            sync_bar  <= 1'b1;
            din       <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            gap_cnt   <= GW'(GAP_CYCLES - 1);
            if (cur) begin
              done1 <= 1'b1;
            end else begin
              done0 <= 1'b1;
            end
            state     <= GAP;
          end else begin
            din     <= shreg[FRAME_BITS-2];
            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt - BW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          sync_bar <= 1'b1;
          din      <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Self-checking bench for dac_spi_arbiter: a frame-timeline reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_dac_spi_arbiter;
  localparam int FB   = 24;
  localparam int GAPC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          req0, req1;
  logic [FB-1:0] data0, data1;
  logic          ack0, ack1, done0, done1;
  logic          sync_bar, din, busy, last_grant;
  logic [15:0]   frame_count;

  int checks   = 0;
  int failures = 0;

  dac_spi_arbiter #(.FRAME_BITS(FB), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req0(req0), .data0(data0), .ack0(ack0), .done0(done0),
    .req1(req1), .data1(data1), .ack1(ack1), .done1(done1),
    .sync_bar(sync_bar), .din(din), .busy(busy),
    .last_grant(last_grant), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a timeline indexed by k = edges since grant.
  logic          m_active = 1'b0;
  int            m_k      = 0;
  logic          m_g      = 1'b0;
  logic [FB-1:0] m_word   = '0;
  logic          m_last   = 1'b1;
  logic [15:0]   m_count  = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        m_active = 1'b0; m_k = 0; m_last = 1'b1; m_count = '0;
      end else if (m_active) begin
        m_k++;
        if (m_k == FB) m_count = m_count + 16'd1;
        if (m_k == FB + GAPC) m_active = 1'b0;
      end else if (enable && (req0 || req1)) begin
        m_g      = (req0 && req1) ? ~m_last : req1;
        m_word   = m_g ? data1 : data0;
        m_last   = m_g;
        m_active = 1'b1;
        m_k      = 0;
      end
      chk("m_sync_bar", 32'(sync_bar), 32'(!(m_active && m_k < FB)));
      chk("m_din", 32'(din), 32'((m_active && m_k < FB) ? m_word[FB-1-m_k] : 1'b0));
      chk("m_ack0", 32'(ack0), 32'(m_active && m_k == 0 && !m_g));
      chk("m_ack1", 32'(ack1), 32'(m_active && m_k == 0 && m_g));
      chk("m_done0", 32'(done0), 32'(m_active && m_k == FB && !m_g));
      chk("m_done1", 32'(done1), 32'(m_active && m_k == FB && m_g));
      chk("m_busy", 32'(busy), 32'(m_active && m_k <= FB + GAPC - 1));
      chk("m_last_grant", 32'(last_grant), 32'(m_last));
      chk("m_frame_count", 32'(frame_count), 32'(m_count));
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(busy == 1'b0 && sync_bar == 1'b1) && n < 80) begin
      @(negedge clk); n++;
    end
    if (n >= 80) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_pulse(input int which, input string name);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 80) begin
      @(negedge clk); n++;
      case (which)
        0: seen = ack0;
        1: seen = ack1;
        2: seen = done0;
        default: seen = done1;
      endcase
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
  endtask

  logic [FB-1:0] got;
  int lows, cyc, n, last_ack_cyc, high_run;
  logic [3:0] gseq;

  initial begin
    reset = 1'b0; enable = 1'b0; req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_sync_bar", 32'(sync_bar), 32'd1);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    reset = 1'b1;

    // Single frame from requester 0.
    @(negedge clk);
    data0 = 24'hA5F00F; enable = 1'b1; req0 = 1'b1;
    @(negedge clk);
    chk("t1_ack0_latency", 32'(ack0), 32'd1);
    req0 = 1'b0; data0 = '0;
    got[FB-1] = din; lows = sync_bar ? 0 : 1;
    for (int i = FB - 2; i >= 0; i--) begin
      @(negedge clk); got[i] = din; if (!sync_bar) lows++;
    end
    chk("t1_din_word", 32'(got), 32'h00A5F00F);
    chk("t1_sync_low_cycles", 32'(lows), 32'd24);
    @(negedge clk);
    chk("t1_done0", 32'(done0), 32'd1);
    chk("t1_sync_high", 32'(sync_bar), 32'd1);
    chk("t1_frame_count", 32'(frame_count), 32'd1);
    @(negedge clk);
    chk("t1_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_low", 32'(busy), 32'd0);

    // Reset, then both requesters continuously: alternate grants, 27-cycle period.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    data0 = 24'h111111; data1 = 24'h222222;
    n = 0; cyc = 0; last_ack_cyc = 0; high_run = 0; gseq = '0;
    while (n < 4 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (sync_bar) high_run++;
      if (ack0 || ack1) begin
        gseq[n] = ack1;
        if (n > 0) begin
          chk("t2_period", 32'(cyc - last_ack_cyc), 32'd27);
          chk("t2_sync_high_gap", 32'(high_run), 32'd3);
        end
        last_ack_cyc = cyc; high_run = 0; n++;
        if (ack0) req0 = 1'b0; else req1 = 1'b0;
      end else begin
        req0 = 1'b1; req1 = 1'b1;
      end
    end
    chk("t2_grant_count", 32'(n), 32'd4);
    chk("t2_grant_order", 32'(gseq), 32'b1010);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("t2");

    // Enable low blocks the grant; raising it grants on the next edge.
    enable = 1'b0; req1 = 1'b1; data1 = 24'h3C3C3C;
    repeat (8) begin
      @(negedge clk);
      chk("t3_no_ack1", 32'(ack1), 32'd0);
      chk("t3_sync_idle", 32'(sync_bar), 32'd1);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("t3_ack1_after_enable", 32'(ack1), 32'd1);
    req1 = 1'b0;
    // Drop enable while bit 10 is on the wire; frame still completes.
    repeat (13) @(negedge clk);
    enable = 1'b0; req0 = 1'b1;
    repeat (11) @(negedge clk);
    chk("t4_done1", 32'(done1), 32'd1);
    chk("t4_frame_count", 32'(frame_count), 32'd5);
    repeat (10) begin
      @(negedge clk);
      chk("t4_no_new_grant", 32'(ack0), 32'd0);
    end

    // Reset while bit 12 is on the wire.
    data0 = 24'hFFFFFF; enable = 1'b1;
    @(negedge clk);
    chk("t5_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    repeat (11) @(negedge clk);
    chk("t5_din_before_reset", 32'(din), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_async_sync_bar", 32'(sync_bar), 32'd1);
    chk("t5_async_din", 32'(din), 32'd0);
    chk("t5_async_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_no_done0", 32'(done0), 32'd0);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("t5_first_grant_ack0", 32'(ack0), 32'd1);
    chk("t5_first_grant_ack1", 32'(ack1), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("t5");

    // Frame counter wrap.
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    m_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    req1 = 1'b1;
    wait_pulse(1, "t6_ack1");
    req1 = 1'b0;
    wait_pulse(3, "t6_done1");
    chk("t6_frame_count_wrap", 32'(frame_count), 32'd0);
    wait_idle("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
